// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_ctrl
// Purpose  : 8N1 UART transmit controller with a programmable baud divisor.
//            It accepts one byte per frame through a valid/ready handshake and
//            shifts it out LSB first, framed by a start bit and a stop bit.
//            Optional even-parity bit between the data bits and the stop bit.
// Build    : define UART_TX_PARITY_EN to insert the even-parity bit.
// Ports    : Clock    - system clock, all state changes on its rising edge
//            Reset    - synchronous active-high reset
//            BaudDiv  - clock cycles per bit period (0 is treated as 1)
//            TxData   - byte to transmit
//            TxValid  - requester has a byte on TxData
//            TxReady  - controller accepts a byte this cycle (IDLE only)
//            TxSerial - UART line, idle high
//            TxBusy   - frame in progress
//            BaudTick - one-cycle pulse on the last cycle of each bit period
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_ctrl #(
    parameter int DIV_W = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [DIV_W-1:0] BaudDiv,
    input  logic [7:0]       TxData,
    input  logic             TxValid,
    output logic             TxReady,
    output logic             TxSerial,
    output logic             TxBusy,
    output logic             BaudTick
);

    localparam logic [DIV_W-1:0] C_DIV_ONE = DIV_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       shift_q, shift_d;
    logic [DIV_W-1:0] div_q,   div_d;
    logic [DIV_W-1:0] cnt_q,   cnt_d;
    logic [2:0]       bit_q,   bit_d;
    logic             tick;

`ifdef UART_TX_PARITY_EN
    // Parity is taken from the byte at acceptance, because the shift
    // register no longer holds the data once the DATA bits are out.
    logic             parity_q, parity_d;
`endif

    // Last cycle of the current bit period; never asserted while idle.
    assign tick = (state_q != ST_IDLE) && (cnt_q == (div_q - C_DIV_ONE));

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            shift_q  <= '0;
            div_q    <= '0;
            cnt_q    <= '0;
            bit_q    <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        TxReady  = 1'b0;
        TxSerial = 1'b1;
        TxBusy   = 1'b1;
        BaudTick = tick;

        // The divisor counter free-runs over 0..D-1 in every non-idle state.
        if (state_q != ST_IDLE) begin
            cnt_d = tick ? '0 : (cnt_q + C_DIV_ONE);
        end

        case (state_q)
            ST_IDLE: begin
                TxReady = 1'b1;
                TxBusy  = 1'b0;
                if (TxValid) begin
                    state_d  = ST_START;
                    shift_d  = TxData;
                    div_d    = (BaudDiv == '0) ? C_DIV_ONE : BaudDiv;
                    cnt_d    = '0;
                    bit_d    = '0;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^TxData;
`endif
                end
            end

            ST_START: begin
                TxSerial = 1'b0;
                if (tick) begin
                    state_d = ST_DATA;
                end
            end

            ST_DATA: begin
                TxSerial = shift_q[0];
                if (tick) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    // bit_q == 7 means the eighth data bit is finishing now.
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                TxSerial = parity_q;
                if (tick) begin
                    state_d = ST_STOP;
                end
            end
`endif

            ST_STOP: begin
                TxSerial = 1'b1;
                if (tick) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_ctrl
// Purpose  : Self-checking bench for uart_tx_ctrl. A frame-level model turns
//            each accepted byte into a queue of expected per-cycle line values
//            and a per-cycle compare process checks all outputs against it.
//            Directed frames pin the model with hand-computed literals.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_ctrl;

`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
    localparam int LIT_A5 = 'h54A;
    localparam int LIT_3C = 'h478;
`else
    localparam int NB = 10;
    localparam int LIT_A5 = 'h34A;
    localparam int LIT_3C = 'h278;
`endif

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] BaudDiv = 16'd4;
    logic [7:0]  TxData = 8'h00;
    logic        TxValid = 1'b0;
    logic        TxReady, TxSerial, TxBusy, BaudTick;

    int n_cmp = 0;
    int n_bad = 0;

    uart_tx_ctrl #(.DIV_W(16)) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .BaudDiv (BaudDiv),
        .TxData  (TxData),
        .TxValid (TxValid),
        .TxReady (TxReady),
        .TxSerial(TxSerial),
        .TxBusy  (TxBusy),
        .BaudTick(BaudTick)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Frame-level model: one queue entry per expected busy cycle.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic ser;
        logic tick;
    } cyc_t;

    cyc_t exp_q[$];
    bit   armed = 0;

    always @(posedge Clock) begin
        if (Reset) begin
            exp_q.delete();
            armed = 1;
        end else if (exp_q.size() != 0) begin
            void'(exp_q.pop_front());
        end else if (TxValid) begin
            int   d;
            logic bits [0:10];
            d = (BaudDiv == 16'd0) ? 1 : int'(BaudDiv);
            bits[0] = 1'b0;
            for (int i = 0; i < 8; i++) bits[1+i] = TxData[i];
`ifdef UART_TX_PARITY_EN
            bits[9]  = ^TxData;
            bits[10] = 1'b1;
`else
            bits[9]  = 1'b1;
            bits[10] = 1'b1;
`endif
            for (int b = 0; b < NB; b++)
                for (int c = 0; c < d; c++)
                    exp_q.push_back('{ser: bits[b], tick: (c == d - 1)});
        end
    end

    always @(negedge Clock) begin
        if (armed) begin
            if (exp_q.size() == 0) begin
                chk("ready", int'(TxReady), 1);
                chk("busy", int'(TxBusy), 0);
                chk("serial", int'(TxSerial), 1);
                chk("tick", int'(BaudTick), 0);
            end else begin
                chk("ready", int'(TxReady), 0);
                chk("busy", int'(TxBusy), 1);
                chk("serial", int'(TxSerial), int'(exp_q[0].ser));
                chk("tick", int'(BaudTick), int'(exp_q[0].tick));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Directed frame helper: index 0 of the capture is the first START cycle.
    // ------------------------------------------------------------------
    logic cap_ser  [0:255];
    logic cap_busy [0:255];
    logic cap_rdy  [0:255];
    int   busy_cnt, tick_cnt;

    task automatic run_frame(input logic [7:0] data, input int div, input int chg,
                             input int newdiv, input int rst_at, input int ncap);
        @(negedge Clock);
        BaudDiv = 16'(div);
        TxData  = data;
        TxValid = 1'b1;
        @(negedge Clock);
        TxValid  = 1'b0;
        busy_cnt = 0;
        tick_cnt = 0;
        for (int j = 0; j < ncap; j++) begin
            cap_ser[j]  = TxSerial;
            cap_busy[j] = TxBusy;
            cap_rdy[j]  = TxReady;
            if (TxBusy)   busy_cnt++;
            if (BaudTick) tick_cnt++;
            if (j == chg) begin
                BaudDiv = 16'(newdiv);
                TxData  = 8'($urandom);
                TxValid = 1'b1;
            end else begin
                TxValid = 1'b0;
            end
            Reset = (j == rst_at);
            @(negedge Clock);
        end
        Reset   = 1'b0;
        TxValid = 1'b0;
    endtask

    function automatic int bits_at(input int d);
        int v = 0;
        for (int i = 0; i < NB; i++)
            if (cap_ser[i*d + d/2]) v |= (1 << i);
        return v;
    endfunction

    initial begin
        int gap;
        bit got;
        int ones;

        // Reset state
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        chk("rst_ready", int'(TxReady), 1);
        chk("rst_serial", int'(TxSerial), 1);
        chk("rst_busy", int'(TxBusy), 0);
        chk("rst_tick", int'(BaudTick), 0);
        Reset = 1'b0;

        // Basic frame 0xA5, D=4
        run_frame(8'hA5, 4, -1, 0, -1, NB*4 + 6);
        chk("a5_bits", bits_at(4), LIT_A5);
        chk("a5_busy_cycles", busy_cnt, NB*4);
        chk("a5_ticks", tick_cnt, NB);

        // Reset during DATA bit 3 (cycles 16..19 of the frame)
        run_frame(8'hA5, 4, -1, 0, 17, 30);
        chk("midrst_serial", int'(cap_ser[18]), 1);
        chk("midrst_busy", int'(cap_busy[18]), 0);
        chk("midrst_ready", int'(cap_rdy[18]), 1);
        ones = 0;
        for (int j = 18; j < 30; j++) if (cap_ser[j]) ones++;
        chk("midrst_line_high", ones, 12);

        // Back-to-back with TxValid held: 0x00 then 0xFF, D=2
        @(negedge Clock);
        BaudDiv = 16'd2;
        TxData  = 8'h00;
        TxValid = 1'b1;
        @(negedge Clock);
        TxData = 8'hFF;
        gap = 0;
        got = 0;
        for (int j = 0; j < 80 && !got; j++) begin
            if (!TxBusy) gap++;
            if (gap > 0 && TxBusy) got = 1;
            else @(negedge Clock);
        end
        TxValid = 1'b0;
        chk("b2b_second_frame", int'(got), 1);
        chk("b2b_idle_gap", gap, 1);
        for (int j = 0; j < 2*NB; j++) begin
            cap_ser[j] = TxSerial;
            @(negedge Clock);
        end
        chk("b2b_start", int'(cap_ser[1]), 0);
        ones = 0;
        for (int i = 1; i <= 8; i++) if (cap_ser[2*i + 1]) ones++;
        chk("b2b_data_ones", ones, 8);
        chk("b2b_stop", int'(cap_ser[2*(NB-1) + 1]), 1);
        repeat (2) @(negedge Clock);

        // Divisor edge: 0 and 1 give identical one-cycle-per-bit frames
        run_frame(8'h3C, 0, -1, 0, -1, NB + 4);
        chk("div0_bits", bits_at(1), LIT_3C);
        chk("div0_busy", busy_cnt, NB);
        chk("div0_ticks", tick_cnt, NB);
        run_frame(8'h3C, 1, -1, 0, -1, NB + 4);
        chk("div1_bits", bits_at(1), LIT_3C);
        chk("div1_busy", busy_cnt, NB);
        chk("div1_ticks", tick_cnt, NB);

        // Divisor and TxValid changes mid-frame are ignored
        run_frame(8'h5A, 8, 20, 3, -1, NB*8 + 10);
        chk("midchg_busy", busy_cnt, NB*8);
        chk("midchg_ticks", tick_cnt, NB);

`ifdef UART_TX_PARITY_EN
        run_frame(8'h07, 4, -1, 0, -1, 50);
        chk("par07_bit", int'(cap_ser[9*4 + 2]), 1);
        chk("par07_busy", busy_cnt, 44);
        run_frame(8'h03, 4, -1, 0, -1, 50);
        chk("par03_bit", int'(cap_ser[9*4 + 2]), 0);
`endif

        // Randomized traffic with occasional resets
        for (int k = 0; k < 3000; k++) begin
            @(negedge Clock);
            TxValid = ($urandom_range(0, 2) != 0);
            TxData  = 8'($urandom);
            BaudDiv = 16'($urandom_range(0, 5));
            Reset   = ($urandom_range(0, 299) == 0);
        end
        @(negedge Clock);
        Reset   = 1'b0;
        TxValid = 1'b0;
        repeat (120) @(negedge Clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
